// File: rtl/vga_fb_arb_if.sv
// vga_fb_arb_if: host write, framebuffer and line-buffer buses between the arbiter and its environment
interface vga_fb_arb_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              host_req;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              lb_we;
  logic              lb_sel;
  logic [6:0]        lb_addr;
  logic [DATA_W-1:0] lb_wdata;
  modport master (
    input  host_req, host_addr, host_wdata, mem_rdata,
    output host_ack, mem_en, mem_we, mem_addr, mem_wdata, lb_we, lb_sel, lb_addr, lb_wdata
  );
  modport slave (
    output host_req, host_addr, host_wdata, mem_rdata,
    input  host_ack, mem_en, mem_we, mem_addr, mem_wdata, lb_we, lb_sel, lb_addr, lb_wdata
  );
endinterface

// File: rtl/vga_fb_arb.sv
// vga_fb_arb: shares a single-port framebuffer between line prefetch and host writes.
// Define VGA_FB_ARB_STATS_EN to add the stat_lines / stat_overrun statistics outputs.
module vga_fb_arb #(
  parameter int H_VISIBLE  = 640,
  parameter int V_VISIBLE  = 480,
  parameter int V_TOTAL    = 525,
  parameter int LINE_WORDS = 80,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] h_count,
  input  logic [9:0]  v_count,
  vga_fb_arb_if.master bus,
  output logic        busy
`ifdef VGA_FB_ARB_STATS_EN
  ,
  output logic [15:0] stat_lines,
  output logic        stat_overrun
`endif
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t            r_state;
  logic [ADDR_W-1:0] r_wc;
  logic [ADDR_W-1:0] r_base;
  logic              r_sel;
  logic              r_lb_we;
  logic [6:0]        r_lb_addr;
  logic [9:0]        w_tl;
  logic              w_start;
  logic              w_fetch;
  logic              w_host;
  always_comb begin
    w_tl    = (v_count == 10'(V_TOTAL - 1)) ? 10'd0 : v_count + 10'd1;
    w_start = (r_state == IDLE) && (h_count == 11'(H_VISIBLE)) && (w_tl < 10'(V_VISIBLE));
    w_fetch = r_state == FETCH;
    // rst_n gating keeps the combinational host path quiet while reset is held
    w_host  = rst_n && (r_state == IDLE) && !w_start && bus.host_req;
  end
  assign bus.host_ack  = w_host;
  assign bus.mem_en    = w_host | w_fetch;
  assign bus.mem_we    = w_host;
  assign bus.mem_addr  = w_fetch ? r_base + r_wc : (w_host ? bus.host_addr : '0);
  assign bus.mem_wdata = w_host ? bus.host_wdata : '0;
  assign bus.lb_we     = r_lb_we;
  assign bus.lb_sel    = r_sel;
  assign bus.lb_addr   = r_lb_addr;
  assign bus.lb_wdata  = r_lb_we ? bus.mem_rdata : '0;
  assign busy          = r_state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_wc      <= '0;
      r_base    <= '0;
      r_sel     <= 1'b0;
      r_lb_we   <= 1'b0;
      r_lb_addr <= '0;
    end else begin
      r_lb_we   <= w_fetch;
      r_lb_addr <= w_fetch ? r_wc[6:0] : r_lb_addr;
      if (w_start) begin
        r_state <= FETCH;
        r_wc    <= '0;
        r_base  <= ADDR_W'(w_tl * LINE_WORDS);
        r_sel   <= w_tl[0];
      end else if (w_fetch) begin
        r_wc    <= r_wc + 1'b1;
        r_state <= (r_wc == ADDR_W'(LINE_WORDS - 1)) ? DRAIN : FETCH;
      end else if (r_state == DRAIN) begin
        r_state <= IDLE;
      end
    end
  end
`ifdef VGA_FB_ARB_STATS_EN
  logic [15:0] r_lines;
  logic        r_overrun;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lines   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_lines   <= (r_state == DRAIN && r_lines != 16'hFFFF) ? r_lines + 16'd1 : r_lines;
      r_overrun <= r_overrun | ((h_count == 11'd0) && (r_state != IDLE));
    end
  end
  assign stat_lines   = r_lines;
  assign stat_overrun = r_overrun;
`endif
endmodule

// File: tb/tb_vga_fb_arb.sv
// tb_vga_fb_arb: scoreboard bench for vga_fb_arb line prefetch, host writes and reset.
module tb_vga_fb_arb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [10:0] h_count = '0;
  logic [9:0]  v_count = '0;
  logic        busy;
  int          n_chk = 0;
  int          n_fail = 0;
  typedef struct {int k; logic [6:0] a; logic [31:0] d;} lb_t;
  logic [15:0] q_addr[$];
  lb_t         q_lb[$];
  logic [47:0] q_req[$];
  vga_fb_arb_if #(.ADDR_W(16), .DATA_W(32)) bus ();
`ifdef VGA_FB_ARB_STATS_EN
  logic [15:0] stat_lines, stat_lines2;
  logic        stat_overrun, stat_overrun2, busy2;
  vga_fb_arb_if #(.ADDR_W(16), .DATA_W(32)) bus2 ();
  vga_fb_arb #(.LINE_WORDS(200)) dut2 (
    .clk(clk), .rst_n(rst_n), .h_count(h_count), .v_count(v_count), .bus(bus2), .busy(busy2),
    .stat_lines(stat_lines2), .stat_overrun(stat_overrun2)
  );
`endif
  vga_fb_arb dut (
    .clk(clk), .rst_n(rst_n), .h_count(h_count), .v_count(v_count), .bus(bus), .busy(busy)
`ifdef VGA_FB_ARB_STATS_EN
    , .stat_lines(stat_lines), .stat_overrun(stat_overrun)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] f(input logic [15:0] a);
    return {a ^ 16'h5A5A, ~a};
  endfunction
  function automatic logic [92:0] outs();
    return {bus.mem_en, bus.mem_we, bus.host_ack, bus.lb_we, bus.lb_sel, busy,
            bus.mem_addr, bus.mem_wdata, bus.lb_addr, bus.lb_wdata};
  endfunction
  task automatic host_drive();
    bus.host_req = q_req.size() != 0;
    if (q_req.size() != 0) {bus.host_addr, bus.host_wdata} = q_req[0];
  endtask
  task automatic step();
    logic        rd;
    logic [15:0] a;
    rd = bus.mem_en && !bus.mem_we;
    a  = bus.mem_addr;
    @(posedge clk);
    #1;
    bus.mem_rdata = rd ? f(a) : '0;
    h_count = (h_count == 11'd799) ? 11'd0 : h_count + 11'd1;
    host_drive();
    @(negedge clk);
  endtask
  task automatic test_reset();
    bus.host_req   = 1'b1;
    bus.host_addr  = 16'hBEEF;
    bus.host_wdata = 32'h12345678;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (outs() !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0", outs());
    end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask
  task automatic test_fetch(input logic [9:0] v, input bit exp, input logic [15:0] base, input logic sel);
    int          first, last, nrd, nbusy;
    logic [15:0] ea;
    lb_t         e;
    first = -1; last = -1; nrd = 0; nbusy = 0;
    h_count = 11'd638;
    v_count = v;
    if (exp) for (int i = 0; i < 80; i++) q_addr.push_back(base + 16'(i));
    for (int k = 0; k < 200; k++) begin
      if (busy) nbusy++;
      if (bus.mem_en && !bus.mem_we) begin
        nrd++;
        if (first < 0) first = k;
        last = k;
        n_chk++;
        if (q_addr.size() == 0) begin
          n_fail++;
          $display("FAIL fetch_extra_read v=%0d: got read at %h, required no read", v, bus.mem_addr);
        end else begin
          ea = q_addr.pop_front();
          if (bus.mem_addr !== ea) begin
            n_fail++;
            $display("FAIL fetch_addr v=%0d: got %h, required %h", v, bus.mem_addr, ea);
          end
          e.k = k + 1; e.a = 7'(ea - base); e.d = f(ea);
          q_lb.push_back(e);
        end
      end
      if (bus.lb_we) begin
        n_chk++;
        if (q_lb.size() == 0) begin
          n_fail++;
          $display("FAIL lb_extra_write v=%0d: got lb_we at cycle %0d, required none", v, k);
        end else begin
          e = q_lb.pop_front();
          if (k != e.k || bus.lb_addr !== e.a || bus.lb_wdata !== e.d || bus.lb_sel !== sel) begin
            n_fail++;
            $display("FAIL lb_write v=%0d: got cyc %0d addr %h data %h sel %b, required cyc %0d addr %h data %h sel %b",
                     v, k, bus.lb_addr, bus.lb_wdata, bus.lb_sel, e.k, e.a, e.d, sel);
          end
        end
      end
      step();
    end
    n_chk++;
    if (nrd != (exp ? 80 : 0) || (exp && last != first + 79) || q_addr.size() != 0 || q_lb.size() != 0) begin
      n_fail++;
      $display("FAIL fetch_count v=%0d: got %0d reads span %0d..%0d, required %0d consecutive", v, nrd, first, last, exp ? 80 : 0);
    end
    n_chk++;
    if (nbusy != (exp ? 81 : 0)) begin
      n_fail++;
      $display("FAIL busy_cycles v=%0d: got %0d, required %0d", v, nbusy, exp ? 81 : 0);
    end
    if (exp) begin
      n_chk++;
      if (first != 3) begin
        n_fail++;
        $display("FAIL fetch_start v=%0d: got first read at cycle %0d, required 3", v, first);
      end
    end
    q_addr.delete();
    q_lb.delete();
  endtask
  task automatic test_host_write();
    h_count = 11'd100;
    v_count = 10'd10;
    q_req.push_back({16'h1234, 32'hDEADBEEF});
    host_drive();
    #1;
    n_chk++;
    if (bus.host_ack !== 1'b1 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 ||
        {bus.mem_addr, bus.mem_wdata} !== q_req[0]) begin
      n_fail++;
      $display("FAIL host_write: got ack %b en %b we %b addr %h data %h, required 1 1 1 %h",
               bus.host_ack, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, q_req[0]);
    end
    void'(q_req.pop_front());
    step();
    n_chk++;
    if (bus.host_ack !== 1'b0 || bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL host_ack_pulse: got ack %b en %b we %b, required 0 0 0", bus.host_ack, bus.mem_en, bus.mem_we);
    end
  endtask
  task automatic test_back_to_back();
    int nack;
    nack = 0;
    h_count = 11'd200;
    for (int i = 0; i < 4; i++) q_req.push_back({16'h0100 + 16'(i), 32'($urandom)});
    host_drive();
    #1;
    for (int k = 0; k < 8; k++) begin
      if (bus.host_ack) begin
        n_chk++;
        if (k != nack || {bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, q_req[0]}) begin
          n_fail++;
          $display("FAIL b2b_write: got cyc %0d we %b addr %h data %h, required cyc %0d we 1 %h",
                   k, bus.mem_we, bus.mem_addr, bus.mem_wdata, nack, q_req[0]);
        end
        void'(q_req.pop_front());
        nack++;
      end
      step();
    end
    n_chk++;
    if (nack != 4 || q_req.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d acks, required 4", nack);
    end
    q_req.delete();
  endtask
  task automatic test_collision();
    int ackk;
    ackk = -1;
    h_count = 11'd638;
    v_count = 10'd0;
    for (int k = 0; k < 120; k++) begin
      if (k == 2) begin
        q_req.push_back({16'h0042, 32'hCAFEF00D});
        host_drive();
        #1;
      end
      if (bus.host_ack) begin
        n_chk++;
        if (ackk >= 0 || k != 84 || {bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 16'h0042, 32'hCAFEF00D}) begin
          n_fail++;
          $display("FAIL collision_ack: got ack at cyc %0d addr %h data %h, required cyc 84 addr 0042 data cafef00d",
                   k, bus.mem_addr, bus.mem_wdata);
        end
        if (q_req.size() != 0) void'(q_req.pop_front());
        ackk = k;
      end
      step();
    end
    n_chk++;
    if (ackk != 84) begin
      n_fail++;
      $display("FAIL collision_ack_cycle: got %0d, required 84", ackk);
    end
    q_req.delete();
  endtask
  task automatic test_reset_mid();
    int          found;
    logic [10:0] fh;
    logic [15:0] fa;
    logic        fwe, flb;
    found = 0; fh = '0; fa = '0; fwe = 1'b0; flb = 1'b0;
    h_count = 11'd638;
    v_count = 10'd0;
    for (int k = 0; k < 43; k++) step();
    n_chk++;
    if (bus.mem_addr !== 16'd120 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_wc40: got addr %h busy %b, required 0078 1", bus.mem_addr, busy);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (outs() !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %h, required 0", outs());
    end
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 1000 && found == 0; k++) begin
      if (bus.mem_en || bus.lb_we) begin
        found = 1; fh = h_count; fa = bus.mem_addr; fwe = bus.mem_we; flb = bus.lb_we;
      end else step();
    end
    n_chk++;
    if (found == 0 || fh != 11'd641 || fa !== 16'd80 || fwe !== 1'b0 || flb !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_restart: got found %0d h %0d addr %h we %b lb_we %b, required 1 641 0050 0 0",
               found, fh, fa, fwe, flb);
    end
    for (int k = 0; k < 90; k++) step();
  endtask
`ifdef VGA_FB_ARB_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (stat_lines !== 16'd0 || stat_overrun !== 1'b0 || stat_lines2 !== 16'd0 || stat_overrun2 !== 1'b0) begin
      n_fail++;
      $display("FAIL stats_reset: got %h %b %h %b, required 0", stat_lines, stat_overrun, stat_lines2, stat_overrun2);
    end
    step();
    rst_n = 1'b1;
    step();
    test_fetch(10'd0, 1'b1, 16'd80, 1'b1);
    test_fetch(10'd1, 1'b1, 16'd160, 1'b0);
    test_fetch(10'd2, 1'b1, 16'd240, 1'b1);
    n_chk++;
    if (stat_lines !== 16'd3 || stat_overrun !== 1'b0 || stat_overrun2 !== 1'b1) begin
      n_fail++;
      $display("FAIL stats_count: got lines %0d overrun %b overrun200 %b, required 3 0 1",
               stat_lines, stat_overrun, stat_overrun2);
    end
  endtask
`endif
  initial begin
    bus.host_req   = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    bus.mem_rdata  = '0;
`ifdef VGA_FB_ARB_STATS_EN
    bus2.host_req   = 1'b0;
    bus2.host_addr  = '0;
    bus2.host_wdata = '0;
    bus2.mem_rdata  = '0;
`endif
    @(negedge clk);
    test_reset();
    test_fetch(10'd0, 1'b1, 16'd80, 1'b1);
    test_fetch(10'd524, 1'b1, 16'd0, 1'b0);
    test_fetch(10'd478, 1'b1, 16'd38320, 1'b1);
    test_fetch(10'd479, 1'b0, 16'd0, 1'b0);
    test_fetch(10'd500, 1'b0, 16'd0, 1'b0);
    test_host_write();
    test_back_to_back();
    test_collision();
    test_reset_mid();
`ifdef VGA_FB_ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_fb_arb.md
VGA_FB_ARB -- requirements
Module: vga_fb_arb

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640: visible pixels per line; fetch starts at this h_count.
REQ-002 SHALL have parameter V_VISIBLE, default 480: visible lines per frame.
REQ-003 SHALL have parameter V_TOTAL, default 525: total lines per frame, including blanking.
REQ-004 SHALL have parameter LINE_WORDS, default 80: framebuffer words per line.
REQ-005 SHALL have parameter ADDR_W, default 16, and parameter DATA_W, default 32.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have inputs h_count [10:0] and v_count [9:0]: timing counters from the VGA timing generator.
REQ-009 SHALL have input host_req (1 bit), host_addr [ADDR_W-1:0] and host_wdata [DATA_W-1:0]: host write request.
REQ-010 SHALL have output host_ack, 1 bit: one-cycle pulse when the host write is issued.
REQ-011 SHALL have outputs mem_en, mem_we (1 bit each), mem_addr [ADDR_W-1:0] and mem_wdata [DATA_W-1:0]: single-port framebuffer command.
REQ-012 SHALL have input mem_rdata [DATA_W-1:0]: read data, valid one cycle after a read command.
REQ-013 SHALL have outputs lb_we, lb_sel (1 bit each), lb_addr [6:0] and lb_wdata [DATA_W-1:0]: line-buffer write port; lb_sel selects the bank.
REQ-014 SHALL have output busy, 1 bit: high while the FSM is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH and DRAIN.
REQ-016 SHALL compute target line tl = 0 when v_count == V_TOTAL-1, else v_count+1.
REQ-017 SHALL go IDLE->FETCH when h_count == H_VISIBLE and tl < V_VISIBLE; it SHALL load word counter wc=0 and base = tl*LINE_WORDS (ADDR_W bits, truncated).
REQ-018 SHALL, in FETCH, drive mem_en=1, mem_we=0, mem_addr=base+wc every cycle, with wc incrementing by 1.
REQ-019 SHALL go FETCH->DRAIN when the cycle issues wc == LINE_WORDS-1; DRAIN SHALL last exactly one cycle and then return to IDLE.
REQ-020 SHALL assert lb_we one cycle after each FETCH read, with lb_addr = that read's wc, lb_wdata = mem_rdata and lb_sel = tl[0] latched at fetch start.
REQ-021 SHALL, in IDLE with host_req=1 and no fetch start that cycle, drive mem_en=1, mem_we=1, mem_addr=host_addr, mem_wdata=host_wdata and host_ack=1 in the same cycle.
REQ-022 SHALL give priority to fetch start when it coincides with host_req; the host then waits, with no ack, until the next IDLE cycle.
REQ-023 SHALL never assert host_ack in FETCH or DRAIN; the host holds host_req, host_addr and host_wdata stable until acked.
REQ-024 SHALL drive mem_en=0 in DRAIN, and in IDLE without a host request.
REQ-025 SHALL make back-to-back host writes in IDLE possible at one per cycle.
REQ-026 SHALL start no fetch while v_count is in vertical blanking, except on line V_TOTAL-1, which fetches line 0.

Reset
REQ-027 SHALL, on rst_n low at any time (including mid-FETCH), immediately set state=IDLE and wc=0, and drive mem_en, mem_we, host_ack, lb_we, lb_sel and busy to 0, and mem_addr, mem_wdata, lb_addr and lb_wdata to 0.
REQ-028 SHALL, after reset release, wait for the next h_count == H_VISIBLE before any fetch; a partially fetched line is not resumed.

Configuration
REQ-029 SHALL, when macro VGA_FB_ARB_STATS_EN is defined, add outputs stat_lines [15:0] and stat_overrun (1 bit).
REQ-030 SHALL, with the macro defined, increment stat_lines on each DRAIN cycle, saturating at 0xFFFF.
REQ-031 SHALL, with the macro defined, set stat_overrun sticky when h_count == 0 while the state is FETCH or DRAIN.
REQ-032 SHALL clear both statistics only on reset.
REQ-033 SHALL, without the macro, omit those ports and logic, with all other behaviour identical.

Verification
REQ-034 SHALL cover: v_count=0, h_count reaches 640 -> reads at addresses 80..159 on 80 consecutive cycles, lb_we lags by 1 cycle, lb_sel=1, busy=1 for 81 cycles.
REQ-035 SHALL cover: v_count=524, h_count=640 -> fetch of line 0, addresses 0..79, lb_sel=0; v_count=479 -> no fetch.
REQ-036 SHALL cover: host_req with addr=0x1234 and data=0xDEADBEEF in IDLE -> same-cycle mem_we=1, mem_addr=0x1234, host_ack=1 for one cycle.
REQ-037 SHALL cover: host_req raised on the fetch-start cycle -> no ack for 81 cycles, ack on the first IDLE cycle after DRAIN.
REQ-038 SHALL cover: rst_n pulsed low at wc=40 -> outputs 0 immediately, no lb_we afterwards, fetch restarts only at the next h_count=640.
REQ-039 SHALL cover, with VGA_FB_ARB_STATS_EN: 3 line fetches -> stat_lines=3; forced LINE_WORDS=200 -> stat_overrun=1.
